// File: rtl/flash_pkg.sv
// Shared command classes, opcodes and operation encodings for flash_spi users,
// plus the helper that maps (operation, step) onto the SPI command to issue.
package flash_pkg;

  localparam logic [2:0] CLS_RDID  = 3'b000;
  localparam logic [2:0] CLS_WREN  = 3'b001;
  localparam logic [2:0] CLS_SE    = 3'b010;
  localparam logic [2:0] CLS_RDSR1 = 3'b011;
  localparam logic [2:0] CLS_WRDI  = 3'b100;
  localparam logic [2:0] CLS_PP    = 3'b101;
  localparam logic [2:0] CLS_READ  = 3'b110;

  localparam logic [7:0] OPC_RDID  = 8'h90;
  localparam logic [7:0] OPC_WREN  = 8'h06;
  localparam logic [7:0] OPC_SE    = 8'h20;
  localparam logic [7:0] OPC_RDSR1 = 8'h05;
  localparam logic [7:0] OPC_WRDI  = 8'h04;
  localparam logic [7:0] OPC_PP    = 8'h02;
  localparam logic [7:0] OPC_READ  = 8'h03;

  localparam logic [1:0] OP_RDID  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_PROG  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam int SR1_WIP_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_CHECK,
    ST_DONE
  } seq_state_t;

  typedef struct packed {
    logic [2:0] cls;
    logic [7:0] opc;
    logic       use_addr;
  } spi_cmd_t;

  // Erase/program run WREN, then the data command, then RDSR1 for every later step.
  function automatic spi_cmd_t step_cmd(input logic [1:0] sel, input logic [1:0] step);
    spi_cmd_t c;
    c = '{cls: CLS_RDID, opc: OPC_RDID, use_addr: 1'b0};
    case (sel)
      OP_READ: c = '{cls: CLS_READ, opc: OPC_READ, use_addr: 1'b1};
      OP_ERASE, OP_PROG: begin
        if (step == 2'd0) begin
          c = '{cls: CLS_WREN, opc: OPC_WREN, use_addr: 1'b0};
        end else if (step == 2'd1) begin
          if (sel == OP_ERASE) c = '{cls: CLS_SE, opc: OPC_SE, use_addr: 1'b1};
          else                 c = '{cls: CLS_PP, opc: OPC_PP, use_addr: 1'b1};
        end else begin
          c = '{cls: CLS_RDSR1, opc: OPC_RDSR1, use_addr: 1'b0};
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic step_is_last(input logic [1:0] sel, input logic [1:0] step);
    return (sel == OP_RDID) || (sel == OP_READ) || (step == 2'd2);
  endfunction

endpackage

// File: rtl/flash_gap_timer.sv
// Inter-command idle timer: load arms it, expired rises GAP_CYCLES-1 cycles later
// so the caller spends exactly GAP_CYCLES cycles waiting; no backpressure.
module flash_gap_timer #(
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(GAP_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/flash_op_sequencer.sv
// Expands one user flash operation into the ordered flash_spi command series,
// holding each request until spi_done and polling WIP after erase/program.
module flash_op_sequencer
  import flash_pkg::*;
#(
  parameter logic [19:0] POLL_MAX   = 20'd600000,
  parameter int          GAP_CYCLES = 4
) (
  input  logic        clock24M,
  input  logic        flash_rstn,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  input  logic [23:0] op_addr,
  output logic        op_busy,
  output logic        op_done,
  output logic        op_err,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  rd_index,
  output logic [15:0] dev_id,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  input  logic        spi_done,
  input  logic [7:0]  spi_data,
  input  logic        spi_valid
);

  seq_state_t  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  sel_q, sel_d;
  logic [23:0] addr_q, addr_d;
  logic [19:0] poll_q, poll_d;
  logic        wip_q, wip_d;
  logic [1:0]  id_cnt_q, id_cnt_d;
  logic        op_busy_q, op_busy_d;
  logic        op_done_q, op_done_d;
  logic        op_err_q, op_err_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_index_q, rd_index_d;
  logic [15:0] dev_id_q, dev_id_d;
  logic [3:0]  cmd_type_q, cmd_type_d;
  logic [7:0]  flash_cmd_q, flash_cmd_d;
  logic [23:0] flash_addr_q, flash_addr_d;

  spi_cmd_t    cur;
  logic [19:0] poll_next;
  logic        gap_load;
  logic        gap_expired;

  flash_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk     (clock24M),
    .rst_n   (flash_rstn),
    .load    (gap_load),
    .expired (gap_expired)
  );

  assign cur = step_cmd(sel_q, step_q);

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    poll_d       = poll_q;
    wip_d        = wip_q;
    id_cnt_d     = id_cnt_q;
    op_busy_d    = op_busy_q;
    op_done_d    = 1'b0;
    op_err_d     = op_err_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    rd_index_d   = rd_index_q;
    dev_id_d     = dev_id_q;
    cmd_type_d   = cmd_type_q;
    flash_cmd_d  = flash_cmd_q;
    flash_addr_d = flash_addr_q;
    poll_next    = poll_q + 20'd1;
    gap_load     = 1'b0;

    // rd_index names the byte currently on rd_data, so it moves on after the strobe.
    if (rd_valid_q) rd_index_d = rd_index_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          sel_d      = op_sel;
          addr_d     = op_addr;
          op_err_d   = 1'b0;
          poll_d     = '0;
          op_busy_d  = 1'b1;
          step_d     = 2'd0;
          rd_index_d = 8'd0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cmd_type_d   = {1'b1, cur.cls};
        flash_cmd_d  = cur.opc;
        flash_addr_d = cur.use_addr ? addr_q : 24'd0;
        id_cnt_d     = 2'd0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_valid) begin
          if (cur.cls == CLS_RDID) begin
            if (id_cnt_q == 2'd0) dev_id_d = {spi_data, dev_id_q[7:0]};
            if (id_cnt_q == 2'd1) dev_id_d = {dev_id_q[15:8], spi_data};
            if (id_cnt_q != 2'd2) id_cnt_d = id_cnt_q + 2'd1;
          end else if (cur.cls == CLS_READ) begin
            rd_valid_d = 1'b1;
            rd_data_d  = spi_data;
          end else if (cur.cls == CLS_RDSR1) begin
            wip_d = spi_data[SR1_WIP_BIT];
          end
        end
        // Dropping the request bit with spi_done keeps flash_spi from re-launching.
        if (spi_done) begin
          cmd_type_d = {1'b0, cmd_type_q[2:0]};
          gap_load   = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_expired) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cur.cls == CLS_RDSR1) begin
          if (!wip_q) begin
            op_done_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            poll_d = poll_next;
            if (poll_next == POLL_MAX) begin
              op_err_d  = 1'b1;
              op_done_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              state_d = ST_ISSUE;
            end
          end
        end else if (step_is_last(sel_q, step_q)) begin
          op_done_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        op_busy_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock24M or negedge flash_rstn) begin
    if (!flash_rstn) begin
      state_q      <= ST_IDLE;
      step_q       <= 2'd0;
      sel_q        <= 2'd0;
      addr_q       <= 24'd0;
      poll_q       <= 20'd0;
      wip_q        <= 1'b0;
      id_cnt_q     <= 2'd0;
      op_busy_q    <= 1'b0;
      op_done_q    <= 1'b0;
      op_err_q     <= 1'b0;
      rd_data_q    <= 8'd0;
      rd_valid_q   <= 1'b0;
      rd_index_q   <= 8'd0;
      dev_id_q     <= 16'd0;
      cmd_type_q   <= 4'h0;
      flash_cmd_q  <= 8'd0;
      flash_addr_q <= 24'd0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      poll_q       <= poll_d;
      wip_q        <= wip_d;
      id_cnt_q     <= id_cnt_d;
      op_busy_q    <= op_busy_d;
      op_done_q    <= op_done_d;
      op_err_q     <= op_err_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_index_q   <= rd_index_d;
      dev_id_q     <= dev_id_d;
      cmd_type_q   <= cmd_type_d;
      flash_cmd_q  <= flash_cmd_d;
      flash_addr_q <= flash_addr_d;
    end
  end

  assign op_busy    = op_busy_q;
  assign op_done    = op_done_q;
  assign op_err     = op_err_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_index   = rd_index_q;
  assign dev_id     = dev_id_q;
  assign cmd_type   = cmd_type_q;
  assign flash_cmd  = flash_cmd_q;
  assign flash_addr = flash_addr_q;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Bench for flash_op_sequencer: behavioural flash_spi responder plus command and
// read-byte scoreboards, a vector table of operations and two hand-built corner cases.
module tb_flash_op_sequencer;
  import flash_pkg::*;

  localparam logic [19:0] TB_POLL_MAX = 20'd5;

  logic        clock24M = 1'b0;
  logic        flash_rstn = 1'b0;
  logic        op_start = 1'b0;
  logic [1:0]  op_sel = 2'b00;
  logic [23:0] op_addr = 24'd0;
  logic        op_busy, op_done, op_err;
  logic [7:0]  rd_data, rd_index;
  logic        rd_valid;
  logic [15:0] dev_id;
  logic [3:0]  cmd_type;
  logic [7:0]  flash_cmd;
  logic [23:0] flash_addr;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_data = 8'd0;
  logic        spi_valid = 1'b0;

  flash_op_sequencer #(.POLL_MAX(TB_POLL_MAX), .GAP_CYCLES(4)) dut (
    .clock24M(clock24M), .flash_rstn(flash_rstn),
    .op_start(op_start), .op_sel(op_sel), .op_addr(op_addr),
    .op_busy(op_busy), .op_done(op_done), .op_err(op_err),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index), .dev_id(dev_id),
    .cmd_type(cmd_type), .flash_cmd(flash_cmd), .flash_addr(flash_addr),
    .spi_done(spi_done), .spi_data(spi_data), .spi_valid(spi_valid)
  );

  always #5 clock24M = ~clock24M;

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0] exp_cmd[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  sr_script[$];
  logic [7:0]  sr_default = 8'h00;
  logic [15:0] id_val = 16'hEF17;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Behavioural flash_spi: launch on request, stream response bytes, pulse done.
  logic [35:0] m_cap;
  logic [7:0]  m_sr;
  int          m_k, m_lat, m_nb, m_b;
  bit          m_busy = 0, m_wait_low = 0, m_unstable = 0;

  initial begin
    forever begin
      @(negedge clock24M);
      if (!flash_rstn) begin
        m_busy = 0; m_wait_low = 0; spi_valid = 1'b0; spi_done = 1'b0; spi_data = 8'd0;
      end else begin
        spi_valid = 1'b0;
        spi_done  = 1'b0;
        if (m_wait_low) begin
          if (!cmd_type[3]) m_wait_low = 0;
        end else if (!m_busy && cmd_type[3]) begin
          m_cap = {cmd_type, flash_cmd, flash_addr};
          if (exp_cmd.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_unexpected: got %0h, required no command", m_cap);
          end else begin
            chk("cmd_order", 64'(m_cap), 64'(exp_cmd.pop_front()));
          end
          m_busy = 1; m_k = 0; m_unstable = 0;
          m_lat = (flash_cmd == OPC_PP) ? 20 : 2;
          m_nb  = (flash_cmd == OPC_RDID) ? 2 : (flash_cmd == OPC_READ) ? 256 :
                  (flash_cmd == OPC_RDSR1) ? 1 : 0;
          if (flash_cmd == OPC_RDSR1) m_sr = (sr_script.size() != 0) ? sr_script.pop_front() : sr_default;
        end else if (m_busy) begin
          if ({cmd_type, flash_cmd, flash_addr} != m_cap) m_unstable = 1;
          if (m_k >= m_lat && m_k < m_lat + m_nb) begin
            m_b = m_k - m_lat;
            spi_valid = 1'b1;
            if (m_cap[31:24] == OPC_RDID)       spi_data = (m_b == 0) ? id_val[15:8] : id_val[7:0];
            else if (m_cap[31:24] == OPC_READ)  spi_data = m_b[7:0];
            else                                spi_data = m_sr;
          end else if (m_k == m_lat + m_nb) begin
            spi_done = 1'b1; m_busy = 0; m_wait_low = 1;
            chk("req_held_stable", 64'(m_unstable), 64'd0);
          end
          m_k++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock24M);
      if (flash_rstn && rd_valid) begin
        if (exp_rd.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rd_unexpected: got idx %0d data %0h, required no byte", rd_index, rd_data);
        end else begin
          chk("rd_idx_data", 64'({rd_index, rd_data}), 64'(exp_rd.pop_front()));
        end
      end
    end
  end

  // CS-high time between commands, counted in cycles with the request bit low.
  int gap_cnt = 0;
  bit have_fall = 0, prev_req = 0;
  initial begin
    forever begin
      @(negedge clock24M);
      if (!flash_rstn) begin
        have_fall = 0; prev_req = 0; gap_cnt = 0;
      end else begin
        if (cmd_type[3] && !prev_req && have_fall) begin
          n_cmp++;
          if (gap_cnt < 4) begin
            n_err++;
            $display("FAIL cmd_gap: got %0d idle cycles, required at least 4", gap_cnt);
          end
        end
        if (!cmd_type[3] && prev_req) begin have_fall = 1; gap_cnt = 0; end
        if (!cmd_type[3]) gap_cnt++;
        prev_req = cmd_type[3];
      end
    end
  end

  localparam logic [35:0] C_WREN = {4'b1001, OPC_WREN, 24'd0};
  localparam logic [35:0] C_RDSR = {4'b1011, OPC_RDSR1, 24'd0};

  task automatic push_expect(input logic [1:0] sel, input logic [23:0] addr,
                             input int polls, input logic exp_err);
    case (sel)
      OP_RDID: exp_cmd.push_back({4'b1000, OPC_RDID, 24'd0});
      OP_READ: begin
        exp_cmd.push_back({4'b1110, OPC_READ, addr});
        for (int i = 0; i < 256; i++) exp_rd.push_back({i[7:0], i[7:0]});
      end
      default: begin
        exp_cmd.push_back(C_WREN);
        if (sel == OP_ERASE) exp_cmd.push_back({4'b1010, OPC_SE, addr});
        else                 exp_cmd.push_back({4'b1101, OPC_PP, addr});
        sr_default = exp_err ? 8'h03 : 8'h00;
        if (exp_err) begin
          for (int i = 0; i < int'(TB_POLL_MAX); i++) exp_cmd.push_back(C_RDSR);
        end else begin
          for (int i = 0; i < polls; i++) begin
            sr_script.push_back(8'h01);
            exp_cmd.push_back(C_RDSR);
          end
          sr_script.push_back(8'h00);
          exp_cmd.push_back(C_RDSR);
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] sel, input logic [23:0] addr, input int polls,
                        input logic exp_err, input logic [15:0] id, input bit poke);
    bit got;
    id_val = id;
    push_expect(sel, addr, polls, exp_err);
    @(negedge clock24M);
    op_sel = sel; op_addr = addr; op_start = 1'b1;
    @(negedge clock24M);
    op_start = 1'b0;
    chk("busy_after_start", 64'(op_busy), 64'd1);
    got = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clock24M);
      op_start = 1'b0;
      if (op_done) begin
        got = 1;
        if (poke) begin op_sel = OP_READ; op_start = 1'b1; end
        break;
      end
      if (poke && c == 3) begin op_sel = OP_READ; op_start = 1'b1; end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL op_done_timeout: got no op_done, required one within 20000 cycles");
    end else begin
      chk("busy_on_done", 64'(op_busy), 64'd1);
      chk("op_err", 64'(op_err), 64'(exp_err));
    end
    @(negedge clock24M);
    op_start = 1'b0;
    chk("busy_after_done", 64'(op_busy), 64'd0);
    chk("done_one_pulse", 64'(op_done), 64'd0);
    chk("op_err_held", 64'(op_err), 64'(exp_err));
    if (poke) begin
      repeat (10) @(negedge clock24M);
      chk("poke_ignored_busy", 64'(op_busy), 64'd0);
    end
    chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    if (sel == OP_RDID) chk("dev_id", 64'(dev_id), 64'(id));
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [23:0] addr;
    int          polls;
    logic        exp_err;
    logic [15:0] id;
  } vec_t;

  vec_t vecs[6];
  bit   seen;

  initial begin
    vecs[0] = '{OP_RDID,  24'h000000, 0, 1'b0, 16'hEF17};
    vecs[1] = '{OP_ERASE, 24'h012000, 3, 1'b0, 16'h0000};
    vecs[2] = '{OP_READ,  24'h000100, 0, 1'b0, 16'h0000};
    vecs[3] = '{OP_PROG,  24'h000200, 1, 1'b0, 16'h0000};
    vecs[4] = '{OP_ERASE, 24'h034000, 0, 1'b1, 16'h0000};
    vecs[5] = '{OP_RDID,  24'h000000, 0, 1'b0, 16'hC218};

    repeat (3) @(negedge clock24M);
    chk("rst_busy", 64'(op_busy), 64'd0);
    chk("rst_done", 64'(op_done), 64'd0);
    chk("rst_err", 64'(op_err), 64'd0);
    chk("rst_rd", 64'({rd_valid, rd_index, rd_data}), 64'd0);
    chk("rst_dev_id", 64'(dev_id), 64'd0);
    chk("rst_spi_if", 64'({cmd_type, flash_cmd, flash_addr}), 64'd0);
    flash_rstn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].sel, vecs[v].addr, vecs[v].polls, vecs[v].exp_err, vecs[v].id, 1'b0);
    end

    // op_start while busy and on the op_done cycle are both dropped.
    run_op(OP_RDID, 24'h0, 0, 1'b0, 16'h1234, 1'b1);
    run_op(OP_RDID, 24'h0, 0, 1'b0, 16'h5678, 1'b0);

    // Reset in the middle of a page program.
    id_val = 16'h0000;
    sr_default = 8'h00;
    exp_cmd.push_back(C_WREN);
    exp_cmd.push_back({4'b1101, OPC_PP, 24'h005500});
    @(negedge clock24M);
    op_sel = OP_PROG; op_addr = 24'h005500; op_start = 1'b1;
    @(negedge clock24M);
    op_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock24M);
      if (cmd_type[3] && flash_cmd == OPC_PP) begin seen = 1; break; end
    end
    chk("pp_issued", 64'(seen), 64'd1);
    repeat (5) @(negedge clock24M);
    flash_rstn = 1'b0;
    #1;
    chk("mid_rst_cmd_type", 64'(cmd_type), 64'd0);
    chk("mid_rst_busy", 64'(op_busy), 64'd0);
    chk("mid_rst_spi_if", 64'({flash_cmd, flash_addr}), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock24M);
      chk("mid_rst_no_done", 64'(op_done), 64'd0);
    end
    flash_rstn = 1'b1;
    chk("mid_rst_cmds", 64'(exp_cmd.size()), 64'd0);
    run_op(OP_RDID, 24'h0, 0, 1'b0, 16'hEF17, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flash_op_sequencer.md
Name: flash_op_sequencer

Overview:
- Command sequencer in front of flash_spi. Turns one high-level user operation into the ordered SPI command series: read ID, sector erase, page program, read page.
- For erase and program it inserts Write Enable first, then polls Status Register 1 until WIP clears.
- Sits between the application logic and flash_spi; it is the only master of flash_spi's cmd_type/flash_cmd/flash_addr inputs.

Parameters:
- POLL_MAX, 20'd600000: maximum status polls before an erase/program is declared failed (timeout).
- GAP_CYCLES, 4: clock24M cycles of idle inserted between consecutive SPI commands (CS-high time).

Ports:
- clock24M  in  1  system clock, same clock as flash_spi; all logic on posedge
- flash_rstn  in  1  asynchronous active-low reset
- op_start  in  1  one-cycle request; ignored while op_busy=1
- op_sel  in  2  00 read ID, 01 sector erase, 10 page program, 11 read page (256 B)
- op_addr  in  24  flash byte address, sampled with op_start
- op_busy  out  1  high from the cycle after op_start to the op_done cycle inclusive
- op_done  out  1  one-cycle completion pulse
- op_err  out  1  timeout flag; valid with op_done, held until next op_start
- rd_data  out  8  read-page byte
- rd_valid  out  1  one-cycle strobe per rd_data byte
- rd_index  out  8  index of current rd_data within the page, 0..255
- dev_id  out  16  {manufacturer, device} from the last read ID
- cmd_type  out  4  to flash_spi: bit3 request, [2:0] command class
- flash_cmd  out  8  to flash_spi opcode
- flash_addr  out  24  to flash_spi address
- spi_done  in  1  flash_spi Done_Sig
- spi_data  in  8  flash_spi mydata_o
- spi_valid  in  1  flash_spi myvalid_o

Behaviour:
- Reset values: op_busy=0, op_done=0, op_err=0, rd_valid=0, rd_index=0, rd_data=0, dev_id=0, cmd_type=4'h0, flash_cmd=0, flash_addr=0, state IDLE, poll counter 0.
- Command classes (cmd_type[2:0] / opcode):
  - WREN: 001 / 0x06
  - WRDI: 100 / 0x04
  - SE: 010 / 0x20
  - RDSR1: 011 / 0x05
  - PP: 101 / 0x02
  - READ: 110 / 0x03
  - RDID: 000 / 0x90, addr 0
- Issue rule: ISSUE drives cmd_type={1,class}, flash_cmd and flash_addr together. All three are held stable until spi_done is seen high. In that same cycle cmd_type[3] drops to 0 and the FSM goes to GAP, so flash_spi cannot re-trigger. No new issue until GAP_CYCLES have elapsed.
- States: IDLE, ISSUE, WAIT, GAP, CHECK, DONE. A step register selects the current command from the op sequence:
  - read ID: RDID
  - read page: READ
  - erase: WREN, SE, RDSR1 repeated
  - program: WREN, PP, RDSR1 repeated
- IDLE: on op_start, latch op_sel/op_addr, clear op_err and poll count, set op_busy, go to ISSUE with step 0.
- WAIT: captures spi_valid bytes.
  - RDID: first byte goes to dev_id[15:8], second to dev_id[7:0].
  - READ: rd_data=spi_data and rd_valid=1 for one cycle, registered one cycle after spi_valid. rd_index starts at 0 and increments after each byte; after 255 it wraps to 0.
  - RDSR1: latch the status byte.
- GAP to CHECK.
- CHECK:
  - If the last command was RDSR1: if bit0=0, go to DONE. Otherwise increment the poll count; if count==POLL_MAX, set op_err and go to DONE; else ISSUE RDSR1 again.
  - Otherwise advance step and go to ISSUE, or go to DONE if the sequence is complete.
- DONE: op_done=1 for one cycle, op_busy=0 the following cycle, return to IDLE.
- op_start while busy: ignored, no queuing.
- op_start in the same cycle as op_done: ignored (op_busy still 1).
- Reset mid-operation: every output returns to its reset value immediately, including cmd_type[3]=0. The flash may be left mid-erase; software re-polls.
- spi_valid outside WAIT: ignored.

Decomposition:
- Shared package flash_pkg holds:
  - cmd_type class constants and opcode constants (shared with flash_spi users)
  - op_sel encodings
  - SR1 WIP bit index
- Optional sub-module flash_gap_timer: a GAP_CYCLES down-counter with load/expire. Otherwise a single module.

Test Plan:
- Read ID: op_sel=00, flash model returns 0xEF,0x17 -> cmd_type 4'b1000, flash_cmd 0x90, addr 0; dev_id=16'hEF17; one op_done, op_err=0.
- Erase at 0x012000, model busy for 3 polls -> command order WREN(0x06), SE(0x20, addr 0x012000), RDSR1 x4 (SR=0x01,0x01,0x01,0x00); op_done once; each issue separated by ≥4 idle cycles.
- Read page at 0x000100, model data = index -> 256 rd_valid pulses; rd_data==rd_index for 0..255; op_done after the last byte.
- Timeout: POLL_MAX=5, SR always 0x03 -> exactly 5 RDSR1 polls, op_done with op_err=1.
- op_start pulsed while busy and again on the op_done cycle -> both ignored; the next op_start after op_busy falls is accepted.
- Reset asserted during PP wait -> cmd_type=0, op_busy=0 within the reset, no op_done; a fresh read ID afterwards completes normally.
